// File: rtl/alu_6502.sv
// rtl/alu_6502.sv - 6502-style 8-bit ALU with registered C/V/Z/N flags (optional SL mode via ALU_SHIFT_LEFT_EN)
module alu_6502 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] alu_a,
    input  logic [WIDTH-1:0] alu_b,
    input  logic [4:0]       mode,
    input  logic             carry_in,
    input  logic             latch,
    output logic [WIDTH-1:0] alu_out,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero,
    output logic             sign,
    output logic             c_q,
    output logic             v_q,
    output logic             z_q,
    output logic             n_q
);

    localparam logic [4:0] MODE_ADD = 5'd0;
    localparam logic [4:0] MODE_AND = 5'd1;
    localparam logic [4:0] MODE_OR  = 5'd2;
    localparam logic [4:0] MODE_EOR = 5'd3;
    localparam logic [4:0] MODE_SR  = 5'd4;
    localparam logic [4:0] MODE_SUB = 5'd5;
`ifdef ALU_SHIFT_LEFT_EN
    localparam logic [4:0] MODE_SL  = 5'd6;
`endif

    localparam int MSB = WIDTH - 1;

    // Shared adder: SUB feeds the inverted B operand, so carry_in=1 means "no borrow".
    logic [WIDTH-1:0] add_b;
    logic [WIDTH:0]   sum;

    // Select adder B operand and form the WIDTH+1-bit sum
    always_comb begin
        add_b = (mode == MODE_SUB) ? ~alu_b : alu_b;
        sum   = {1'b0, alu_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, carry_in};
    end

    // Result, carry and overflow per mode; unused modes produce all zeros
    always_comb begin
        alu_out   = '0;
        carry_out = 1'b0;
        overflow  = 1'b0;
        case (mode)
            MODE_ADD: begin
                alu_out   = sum[WIDTH-1:0];
                carry_out = sum[WIDTH];
                overflow  = (alu_a[MSB] == alu_b[MSB]) && (sum[MSB] != alu_a[MSB]);
            end
            MODE_SUB: begin
                alu_out   = sum[WIDTH-1:0];
                carry_out = sum[WIDTH];
                overflow  = (alu_a[MSB] != alu_b[MSB]) && (sum[MSB] != alu_a[MSB]);
            end
            MODE_AND: alu_out = alu_a & alu_b;
            MODE_OR:  alu_out = alu_a | alu_b;
            MODE_EOR: alu_out = alu_a ^ alu_b;
            MODE_SR: begin
                alu_out   = {carry_in, alu_a[WIDTH-1:1]};
                carry_out = alu_a[0];
            end
`ifdef ALU_SHIFT_LEFT_EN
            MODE_SL: begin
                alu_out   = {alu_a[WIDTH-2:0], carry_in};
                carry_out = alu_a[MSB];
            end
`endif
            default: begin
                alu_out   = '0;
                carry_out = 1'b0;
                overflow  = 1'b0;
            end
        endcase
    end

    // Zero and sign always reflect the final result
    always_comb begin
        zero = (alu_out == '0);
        sign = alu_out[MSB];
    end

    // Status-register copy of the flags; reset wins over latch
    always_ff @(posedge clk) begin
        if (reset) begin
            c_q <= 1'b0;
            v_q <= 1'b0;
            z_q <= 1'b0;
            n_q <= 1'b0;
        end else if (latch) begin
            c_q <= carry_out;
            v_q <= overflow;
            z_q <= zero;
            n_q <= sign;
        end
    end

endmodule

// File: tb/tb_alu_6502.sv
// tb/tb_alu_6502.sv - directed table-driven bench for alu_6502 (honours ALU_SHIFT_LEFT_EN)
module tb_alu_6502;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [4:0] mode;
    logic       carry_in;
    logic       latch;
    logic [7:0] alu_out;
    logic       carry_out;
    logic       overflow;
    logic       zero;
    logic       sign;
    logic       c_q;
    logic       v_q;
    logic       z_q;
    logic       n_q;

    int pass_cnt = 0;
    int total_cnt = 0;

    alu_6502 #(.WIDTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .mode      (mode),
        .carry_in  (carry_in),
        .latch     (latch),
        .alu_out   (alu_out),
        .carry_out (carry_out),
        .overflow  (overflow),
        .zero      (zero),
        .sign      (sign),
        .c_q       (c_q),
        .v_q       (v_q),
        .z_q       (z_q),
        .n_q       (n_q)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [4:0] mode;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] out;
        logic       c;
        logic       v;
        logic       z;
        logic       n;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%03h expected 0x%03h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input logic [4:0] m, input logic [7:0] a, input logic [7:0] b, input logic cin);
        mode = m;
        alu_a = a;
        alu_b = b;
        carry_in = cin;
    endtask

    initial begin
        //                name          mode   a      b      cin   out    C     V     Z     N
        vecs.push_back('{"add_ovf",     5'd0,  8'h50, 8'h50, 1'b0, 8'hA0, 1'b0, 1'b1, 1'b0, 1'b1});
        vecs.push_back('{"add_wrap",    5'd0,  8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{"add_wrap_c",  5'd0,  8'hFF, 8'h01, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"add_neg_ovf", 5'd0,  8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{"sub_ovf",     5'd5,  8'h50, 8'hB0, 1'b1, 8'hA0, 1'b0, 1'b1, 1'b0, 1'b1});
        vecs.push_back('{"sub_simple",  5'd5,  8'h05, 8'h03, 1'b1, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"sub_wrap",    5'd5,  8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{"sub_neg_ovf", 5'd5,  8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{"sub_borrow",  5'd5,  8'h05, 8'h03, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"sr_ror",      5'd4,  8'h81, 8'h55, 1'b1, 8'hC0, 1'b1, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{"sr_lsr",      5'd4,  8'h81, 8'h55, 1'b0, 8'h40, 1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"and",         5'd1,  8'hF0, 8'h3C, 1'b1, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"or",          5'd2,  8'h0F, 8'hF0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{"eor_zero",    5'd3,  8'hAA, 8'hAA, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{"unused7",     5'd7,  8'hFF, 8'hFF, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{"unused31",    5'd31, 8'hFF, 8'hFF, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0});
`ifdef ALU_SHIFT_LEFT_EN
        vecs.push_back('{"sl_asl",      5'd6,  8'h81, 8'h00, 1'b0, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"sl_rol",      5'd6,  8'h40, 8'h00, 1'b1, 8'h81, 1'b0, 1'b0, 1'b0, 1'b1});
`else
        vecs.push_back('{"mode6_off",   5'd6,  8'h81, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0});
`endif

        reset = 1'b1;
        latch = 1'b0;
        apply(5'd0, 8'h00, 8'h00, 1'b0);
        tick();
        tick();
        check("reset_flags", {8'h00, c_q, v_q, z_q, n_q}, 12'h000);

        // Combinational outputs follow inputs even while reset is held
        apply(5'd0, 8'h50, 8'h50, 1'b0);
        #1;
        check("comb_in_reset", {alu_out, carry_out, overflow, zero, sign}, {8'hA0, 4'b0101});
        tick();
        reset = 1'b0;

        foreach (vecs[i]) begin
            apply(vecs[i].mode, vecs[i].a, vecs[i].b, vecs[i].cin);
            #1;
            check(vecs[i].name, {alu_out, carry_out, overflow, zero, sign},
                  {vecs[i].out, vecs[i].c, vecs[i].v, vecs[i].z, vecs[i].n});
        end

        // Latch EOR zero result
        @(negedge clk);
        apply(5'd3, 8'hAA, 8'hAA, 1'b1);
        latch = 1'b1;
        tick();
        check("latch_eor", {8'h00, c_q, v_q, z_q, n_q}, {8'h00, 4'b0010});

        // latch=0 holds despite changing inputs
        @(negedge clk);
        latch = 1'b0;
        apply(5'd0, 8'h50, 8'h50, 1'b0);
        tick();
        tick();
        check("hold", {8'h00, c_q, v_q, z_q, n_q}, {8'h00, 4'b0010});

        // Latch ADD overflow result
        @(negedge clk);
        latch = 1'b1;
        tick();
        check("latch_add", {8'h00, c_q, v_q, z_q, n_q}, {8'h00, 4'b0101});

        // Latch SUB no-borrow carry
        @(negedge clk);
        apply(5'd5, 8'h05, 8'h03, 1'b1);
        tick();
        check("latch_sub", {8'h00, c_q, v_q, z_q, n_q}, {8'h00, 4'b1000});

        // Reset beats latch in the same cycle
        @(negedge clk);
        apply(5'd0, 8'h50, 8'h50, 1'b0);
        latch = 1'b1;
        reset = 1'b1;
        tick();
        check("reset_over_latch", {8'h00, c_q, v_q, z_q, n_q}, 12'h000);

        @(negedge clk);
        reset = 1'b0;
        latch = 1'b0;
        tick();
        check("post_reset_hold", {8'h00, c_q, v_q, z_q, n_q}, 12'h000);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
